// File: rtl/universal_shift_register_n.sv
// rtl/universal_shift_register_n.sv - N-bit universal shift register with burst engine
// Optional parity output enabled by defining USR_PARITY_EN.
module universal_shift_register_n #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_r,
  output logic             ser_out_l
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  function automatic logic [WIDTH-1:0] f_shift(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             sin_r,
    input logic             sin_l
  );
    case (m)
      3'b001:  f_shift = {sin_r, d[WIDTH-1:1]};
      3'b010:  f_shift = {d[WIDTH-2:0], sin_l};
      3'b011:  f_shift = ld;
      3'b100:  f_shift = {d[0], d[WIDTH-1:1]};
      3'b101:  f_shift = {d[WIDTH-2:0], d[WIDTH-1]};
      3'b110:  f_shift = {d[WIDTH-1], d[WIDTH-1:1]};
      3'b111:  f_shift = '0;
      default: f_shift = d;
    endcase
  endfunction

  // Non-shifting ops (hold/load/clear) finish a burst after a single edge.
  assign w_last = (r_remaining == CNT_W'(1)) || (r_mode == 3'b000) ||
                  (r_mode == 3'b011) || (r_mode == 3'b111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data      <= RESET_VAL;
      r_mode      <= 3'b000;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mode      <= mode;
            r_remaining <= count;
            if (count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            if (r_state == S_IDLE && en)
              r_data <= f_shift(mode, r_data, data_in, ser_in_r, ser_in_l);
          end
        end
        S_RUN: begin
          r_data <= f_shift(r_mode, r_data, data_in, ser_in_r, ser_in_l);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign data_out  = r_data;
  assign ser_out_r = r_data[0];
  assign ser_out_l = r_data[WIDTH-1];
`ifdef USR_PARITY_EN
  assign parity    = ^r_data;
`endif

endmodule

// File: tb/tb_universal_shift_register_n.sv
// tb/tb_universal_shift_register_n.sv - directed-vector bench for universal_shift_register_n
// Parity vectors are included when USR_PARITY_EN is defined.
module tb_universal_shift_register_n;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       ser_in_r;
  logic       ser_in_l;
  logic [7:0] data_in;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic       ser_out_r;
  logic       ser_out_l;
`ifdef USR_PARITY_EN
  logic       parity;
`endif

  int vectors;
  int errors;

  universal_shift_register_n #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .data_in   (data_in),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
`ifdef USR_PARITY_EN
    .parity    (parity),
`endif
    .data_out  (data_out),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe busy/done/data together after an edge.
  task automatic expect_state(input string name, input logic eb, input logic ed, input logic [7:0] edata);
    vectors++;
    if (busy !== eb || done !== ed || data_out !== edata) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b data=%h, want busy=%b done=%b data=%h",
               name, busy, done, data_out, eb, ed, edata);
    end
  endtask

  task automatic single(input logic [2:0] m, input logic [7:0] d);
    en = 1'b1; mode = m; data_in = d;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    expect_state("reset_initial", 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b0;
    single(3'b011, 8'hFF);
    expect_state("load_ff", 1'b0, 1'b0, 8'hFF);
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_reset", 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_single_step();
    single(3'b011, 8'hB5);
    expect_state("load_b5", 1'b0, 1'b0, 8'hB5);
    vectors++;
    if (ser_out_r !== 1'b1 || ser_out_l !== 1'b1) begin
      errors++;
      $display("FAIL ser_out_b5: got r=%b l=%b want r=1 l=1", ser_out_r, ser_out_l);
    end
`ifdef USR_PARITY_EN
    vectors++;
    if (parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_b5: got %b want 1", parity);
    end
`endif
    ser_in_r = 1'b1;
    single(3'b001, 8'h00);
    expect_state("sr_in1", 1'b0, 1'b0, 8'hDA);
    ser_in_l = 1'b0;
    single(3'b010, 8'h00);
    expect_state("sl_in0", 1'b0, 1'b0, 8'hB4);
`ifdef USR_PARITY_EN
    vectors++;
    if (parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_b4: got %b want 0", parity);
    end
`endif
    vectors++;
    if (ser_out_r !== 1'b0 || ser_out_l !== 1'b1) begin
      errors++;
      $display("FAIL ser_out_b4: got r=%b l=%b want r=0 l=1", ser_out_r, ser_out_l);
    end
    single(3'b000, 8'h00);
    expect_state("hold", 1'b0, 1'b0, 8'hB4);
    mode = 3'b001;
    tick();
    expect_state("en0_hold", 1'b0, 1'b0, 8'hB4);
    single(3'b101, 8'h00);
    expect_state("rol", 1'b0, 1'b0, 8'h69);
    single(3'b111, 8'h00);
    expect_state("clear", 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_burst_ror();
    single(3'b011, 8'h81);
    start = 1'b1; mode = 3'b100; count = 4'd3;
    tick();
    start = 1'b0; mode = 3'b000;
    expect_state("ror_e0", 1'b1, 1'b0, 8'h81);
    tick(); expect_state("ror_e1", 1'b1, 1'b0, 8'hC0);
    tick(); expect_state("ror_e2", 1'b1, 1'b0, 8'h60);
    tick(); expect_state("ror_e3", 1'b0, 1'b1, 8'h30);
    tick(); expect_state("ror_after", 1'b0, 1'b0, 8'h30);
  endtask

  task automatic test_burst_asr();
    single(3'b011, 8'h90);
    start = 1'b1; mode = 3'b110; count = 4'd2;
    tick();
    expect_state("asr_e0", 1'b1, 1'b0, 8'h90);
    mode = 3'b011; data_in = 8'h00; count = 4'd15; en = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    expect_state("asr_e1_start_ignored", 1'b1, 1'b0, 8'hC8);
    tick(); expect_state("asr_e2", 1'b0, 1'b1, 8'hE4);
    tick(); expect_state("asr_after", 1'b0, 1'b0, 8'hE4);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 3'b001; count = 4'd0;
    tick();
    start = 1'b0;
    expect_state("count0_done", 1'b0, 1'b1, 8'hE4);
    tick(); expect_state("count0_after", 1'b0, 1'b0, 8'hE4);
    start = 1'b1; en = 1'b1; mode = 3'b001; count = 4'd1; ser_in_r = 1'b0;
    tick();
    start = 1'b0; en = 1'b0;
    expect_state("start_en_no_step", 1'b1, 1'b0, 8'hE4);
    tick(); expect_state("sr_burst1", 1'b0, 1'b1, 8'h72);
    start = 1'b1; mode = 3'b010; count = 4'd2; ser_in_l = 1'b1;
    tick();
    start = 1'b0;
    expect_state("start_in_done", 1'b1, 1'b0, 8'h72);
    tick(); expect_state("sl_b1", 1'b1, 1'b0, 8'hE5);
    tick(); expect_state("sl_b2", 1'b0, 1'b1, 8'hCB);
    start = 1'b1; mode = 3'b011; count = 4'd5; data_in = 8'h3C;
    tick();
    start = 1'b0;
    expect_state("load_burst_e0", 1'b1, 1'b0, 8'hCB);
    tick(); expect_state("load_burst_one_op", 1'b0, 1'b1, 8'h3C);
    tick(); expect_state("load_burst_after", 1'b0, 1'b0, 8'h3C);
  endtask

  task automatic test_reset_mid_burst();
    single(3'b011, 8'hB5);
    start = 1'b1; mode = 3'b101; count = 4'd5;
    tick();
    start = 1'b0;
    tick(); expect_state("rol_b1", 1'b1, 1'b0, 8'h6B);
    tick(); expect_state("rol_b2", 1'b1, 1'b0, 8'hD6);
    #2;
    reset = 1'b1;
    #1;
    expect_state("mid_reset", 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b0;
    tick(); expect_state("post_reset_1", 1'b0, 1'b0, 8'h00);
    tick(); expect_state("post_reset_2", 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    vectors = 0; errors = 0;
    reset = 1'b1; en = 1'b0; mode = 3'b000; ser_in_r = 1'b0; ser_in_l = 1'b0;
    data_in = 8'h00; start = 1'b0; count = 4'd0;
    test_reset();
    test_single_step();
    test_burst_ror();
    test_burst_asr();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
